// File: rtl/bcd_score_counter_pkg.sv
// ============================================================================
// Module   : bcd_score_counter_pkg
// Purpose  : Shared digit width, max-digit values and 7-segment decode table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_score_counter_pkg;

   localparam int         DIGIT_W       = 4;
   localparam logic [3:0] MAX_DIGIT_BCD = 4'd9;
   localparam logic [3:0] MAX_DIGIT_HEX = 4'hF;

   // Active-low segments, bit 6 = g ... bit 0 = a
   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0011000;
   localparam logic [6:0] SEG_A = 7'b0001000;
   localparam logic [6:0] SEG_B = 7'b0000011;
   localparam logic [6:0] SEG_C = 7'b1000110;
   localparam logic [6:0] SEG_D = 7'b0100001;
   localparam logic [6:0] SEG_E = 7'b0000110;
   localparam logic [6:0] SEG_F = 7'b0001110;

   function automatic logic [6:0] seg_decode(input logic [3:0] i_digit);
      logic [6:0] w_seg;
      w_seg = SEG_0;
      case (i_digit)
         4'h0: w_seg = SEG_0;
         4'h1: w_seg = SEG_1;
         4'h2: w_seg = SEG_2;
         4'h3: w_seg = SEG_3;
         4'h4: w_seg = SEG_4;
         4'h5: w_seg = SEG_5;
         4'h6: w_seg = SEG_6;
         4'h7: w_seg = SEG_7;
         4'h8: w_seg = SEG_8;
         4'h9: w_seg = SEG_9;
         4'hA: w_seg = SEG_A;
         4'hB: w_seg = SEG_B;
         4'hC: w_seg = SEG_C;
         4'hD: w_seg = SEG_D;
         4'hE: w_seg = SEG_E;
         4'hF: w_seg = SEG_F;
         default: w_seg = SEG_0;
      endcase
      return w_seg;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_score_counter_tick_divider.sv
// ============================================================================
// Module   : tick_divider
// Purpose  : Enable-gated down-counter emitting a registered one-cycle tick.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_divider #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic resetn,
   input  logic enable,
   input  logic reload,
   output logic tick
);

   localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_tick;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt  <= LOAD_VAL;
         r_tick <= 1'b0;
      end else if (reload) begin
         r_cnt  <= LOAD_VAL;
         r_tick <= 1'b0;
      end else if (enable) begin
         if (r_cnt == '0) begin
            r_cnt  <= LOAD_VAL;
            r_tick <= 1'b1;
         end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_tick <= 1'b0;
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/bcd_score_counter.sv
// ============================================================================
// Module   : bcd_score_counter
// Purpose  : Multi-digit BCD/hex score counter with bonus add, high score
//            tracking and active-low 7-segment outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_score_counter
   import bcd_score_counter_pkg::*;
#(
   parameter int DIGITS   = 6,
   parameter int TICK_DIV = 50_000_000,
   parameter int BCD      = 1,
   parameter int SATURATE = 1
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    enable,
   input  logic                    clear,
   input  logic                    add_pulse,
   input  logic [3:0]              add_val,
   output logic [DIGIT_W*DIGITS-1:0] count,
   output logic [DIGIT_W*DIGITS-1:0] high_score,
   output logic                    tick,
   output logic                    overflow,
   output logic                    new_high,
   output logic [7*DIGITS-1:0]     hex
);

   localparam int          W         = DIGIT_W * DIGITS;
   localparam logic [3:0]  MAX_DIGIT = (BCD != 0) ? MAX_DIGIT_BCD : MAX_DIGIT_HEX;
   localparam logic [W-1:0] MAX_VAL  = {DIGITS{MAX_DIGIT}};

   logic [W-1:0]    r_count;
   logic [W-1:0]    r_high;
   logic            r_overflow;
   logic            r_new_high;
   logic            w_tick;
   logic [3:0]      w_add_val;
   logic [4:0]      w_inc;
   logic [W-1:0]    w_sum;
   logic [W-1:0]    w_next;
   logic [DIGITS:1] w_carry;
   logic            w_wrap;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk    (clk),
      .resetn (resetn),
      .enable (enable),
      .reload (clear),
      .tick   (w_tick)
   );

   assign w_add_val = ((BCD != 0) && (add_val > 4'd9)) ? 4'd9 : add_val;
   assign w_inc     = {4'd0, w_tick} + ((add_pulse && enable) ? {1'b0, w_add_val} : 5'd0);

   // Ripple adder: digit 0 takes the whole increment, upper digits take the carry
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [4:0] w_dsum;
      logic [3:0] w_dig;
      logic       w_cout;

      if (gi == 0) begin : g_lsd
         assign w_dsum = {1'b0, r_count[3:0]} + w_inc;
      end else begin : g_msd
         assign w_dsum = {1'b0, r_count[gi*DIGIT_W +: DIGIT_W]} + {4'd0, w_carry[gi]};
      end

      always_comb begin
         w_dig  = w_dsum[3:0];
         w_cout = w_dsum[4];
         if (BCD != 0) begin
            w_cout = (w_dsum >= 5'd10);
            if (w_cout) begin
               w_dig = w_dsum[3:0] - 4'd10;
            end
         end
      end

      assign w_sum[gi*DIGIT_W +: DIGIT_W] = w_dig;
      assign w_carry[gi+1]                = w_cout;
   end

   assign w_wrap = w_carry[DIGITS];
   assign w_next = (w_wrap && (SATURATE != 0)) ? MAX_VAL : w_sum;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (clear) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_count <= w_next;
         if (w_wrap) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Valid BCD digits never exceed 9, so an unsigned compare of the packed
   // vector is the digit-wise magnitude compare. The best score is still
   // captured on a clear cycle so the final pre-clear value is not lost.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_high     <= '0;
         r_new_high <= 1'b0;
      end else begin
         if (r_count > r_high) begin
            r_high <= r_count;
         end
         if (clear) begin
            r_new_high <= 1'b0;
         end else if (r_count > r_high) begin
            r_new_high <= 1'b1;
         end
      end
   end

   for (genvar gs = 0; gs < DIGITS; gs++) begin : g_seg
      assign hex[7*gs +: 7] = seg_decode(r_count[gs*DIGIT_W +: DIGIT_W]);
   end

   assign count      = r_count;
   assign high_score = r_high;
   assign tick       = w_tick;
   assign overflow   = r_overflow;
   assign new_high   = r_new_high;

endmodule

`default_nettype wire

// File: tb/tb_bcd_score_counter.sv
// ============================================================================
// Module   : tb_bcd_score_counter
// Purpose  : Self-checking bench for three score counter flavours
//            (BCD wrap, BCD saturate, hex saturate) driven in lock-step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_score_counter;

   localparam int TD = 4;
   localparam int ND = 2;
   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic       clear;
   logic       add_pulse;
   logic [3:0] add_val;

   logic [7:0]  a_cnt  [NI];
   logic [7:0]  a_high [NI];
   logic        a_tick [NI];
   logic        a_ovf  [NI];
   logic        a_new  [NI];
   logic [13:0] a_hex  [NI];

   int n_pass  = 0;
   int n_total = 0;

   int m_cnt  [NI];
   int m_high [NI];
   int m_div  [NI];
   bit m_tick [NI];
   bit m_ovf  [NI];
   bit m_new  [NI];

   bcd_score_counter #(.DIGITS(ND), .TICK_DIV(TD), .BCD(1), .SATURATE(0)) u_dut_bw (
      .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
      .add_pulse(add_pulse), .add_val(add_val),
      .count(a_cnt[0]), .high_score(a_high[0]), .tick(a_tick[0]),
      .overflow(a_ovf[0]), .new_high(a_new[0]), .hex(a_hex[0]));

   bcd_score_counter #(.DIGITS(ND), .TICK_DIV(TD), .BCD(1), .SATURATE(1)) u_dut_bs (
      .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
      .add_pulse(add_pulse), .add_val(add_val),
      .count(a_cnt[1]), .high_score(a_high[1]), .tick(a_tick[1]),
      .overflow(a_ovf[1]), .new_high(a_new[1]), .hex(a_hex[1]));

   bcd_score_counter #(.DIGITS(ND), .TICK_DIV(TD), .BCD(0), .SATURATE(1)) u_dut_hs (
      .clk(clk), .resetn(resetn), .enable(enable), .clear(clear),
      .add_pulse(add_pulse), .add_val(add_val),
      .count(a_cnt[2]), .high_score(a_high[2]), .tick(a_tick[2]),
      .overflow(a_ovf[2]), .new_high(a_new[2]), .hex(a_hex[2]));

   always #5 clk = ~clk;

   function automatic bit is_bcd(int i);
      return (i != 2);
   endfunction

   function automatic bit is_sat(int i);
      return (i != 0);
   endfunction

   function automatic int base_of(int i);
      return is_bcd(i) ? 10 : 16;
   endfunction

   function automatic int max_of(int i);
      return base_of(i) * base_of(i) - 1;
   endfunction

   function automatic logic [7:0] to_vec(int v, int b);
      return {4'(v / b), 4'(v % b)};
   endfunction

   function automatic logic [6:0] seg7(int d);
      case (d)
         0: return 7'b1000000;   1: return 7'b1111001;
         2: return 7'b0100100;   3: return 7'b0110000;
         4: return 7'b0011001;   5: return 7'b0010010;
         6: return 7'b0000010;   7: return 7'b1111000;
         8: return 7'b0000000;   9: return 7'b0011000;
         10: return 7'b0001000;  11: return 7'b0000011;
         12: return 7'b1000110;  13: return 7'b0100001;
         14: return 7'b0000110;  default: return 7'b0001110;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         m_cnt[i]  = 0;
         m_high[i] = 0;
         m_div[i]  = TD - 1;
         m_tick[i] = 1'b0;
         m_ovf[i]  = 1'b0;
         m_new[i]  = 1'b0;
      end
   endtask

   // Score arithmetic on plain integers: value + increment against base^ND - 1
   task automatic model_update();
      if (!resetn) begin
         model_reset();
      end else begin
         for (int i = 0; i < NI; i++) begin
            int add;
            int sum;
            int cur;
            cur = m_cnt[i];
            add = 0;
            if (add_pulse && enable)
               add = (is_bcd(i) && add_val > 9) ? 9 : int'(add_val);
            sum = cur + int'(m_tick[i]) + add;
            if (cur > m_high[i]) begin
               m_high[i] = cur;
               m_new[i]  = 1'b1;
            end
            if (clear) begin
               m_cnt[i]  = 0;
               m_ovf[i]  = 1'b0;
               m_new[i]  = 1'b0;
               m_div[i]  = TD - 1;
               m_tick[i] = 1'b0;
            end else begin
               if (sum > max_of(i)) begin
                  m_ovf[i] = 1'b1;
                  m_cnt[i] = is_sat(i) ? max_of(i) : sum % (max_of(i) + 1);
               end else begin
                  m_cnt[i] = sum;
               end
               if (!enable) begin
                  m_tick[i] = 1'b0;
               end else if (m_div[i] == 0) begin
                  m_div[i]  = TD - 1;
                  m_tick[i] = 1'b1;
               end else begin
                  m_div[i]  = m_div[i] - 1;
                  m_tick[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #2;
   endtask

   task automatic run_until(int i, logic [7:0] target, string name);
      int n;
      n = 0;
      while (to_vec(m_cnt[i], base_of(i)) !== target && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) begin
         n_total++;
         $display("FAIL %s: timeout waiting for count %0h", name, target);
      end
   endtask

   task automatic wait_tick(int i, string name);
      int n;
      n = 0;
      while (!m_tick[i] && n < 20) begin
         step();
         n++;
      end
      if (n >= 20) begin
         n_total++;
         $display("FAIL %s: timeout waiting for tick", name);
      end
   endtask

   // Per-cycle comparison of every instance against the model
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 0; i < NI; i++) begin
            int b;
            b = base_of(i);
            chk($sformatf("cnt%0d", i),  a_cnt[i],  to_vec(m_cnt[i], b));
            chk($sformatf("high%0d", i), a_high[i], to_vec(m_high[i], b));
            chk($sformatf("tick%0d", i), a_tick[i], m_tick[i]);
            chk($sformatf("ovf%0d", i),  a_ovf[i],  m_ovf[i]);
            chk($sformatf("new%0d", i),  a_new[i],  m_new[i]);
            chk($sformatf("hex%0d", i),  a_hex[i],
                {seg7((m_cnt[i] / b) % b), seg7(m_cnt[i] % b)});
         end
      end
   end

   initial begin
      int n;
      int a;
      resetn    = 1'b1;
      enable    = 1'b0;
      clear     = 1'b0;
      add_pulse = 1'b0;
      add_val   = 4'd0;
      #1 resetn = 1'b0;
      model_reset();
      repeat (2) step();
      chk("rst_cnt",  a_cnt[0],  8'h00);
      chk("rst_high", a_high[0], 8'h00);
      chk("rst_tick", a_tick[0], 1'b0);
      chk("rst_ovf",  a_ovf[0],  1'b0);
      chk("rst_hex",  a_hex[0],  14'b1000000_1000000);

      // Ten ticks at one per four cycles
      resetn = 1'b1;
      enable = 1'b1;
      repeat (40) step();
      chk("run_tick40", a_tick[0], 1'b1);
      chk("run_cnt40",  a_cnt[0],  8'h09);
      step();
      chk("run_cnt41",  a_cnt[0],  8'h10);
      chk("run_hex_lo", a_hex[0][6:0],  7'b1000000);
      chk("run_hex_hi", a_hex[0][13:7], 7'b1111001);
      chk("run_high",   a_high[0], 8'h09);
      chk("run_new",    a_new[0],  1'b1);
      chk("run_hexcnt", a_cnt[2],  8'h0A);

      // Pause mid-divide, then resume from the held divider value
      enable = 1'b0;
      repeat (10) step();
      chk("hold_cnt",  a_cnt[0],  8'h10);
      chk("hold_tick", a_tick[0], 1'b0);
      enable = 1'b1;
      repeat (2) step();
      chk("resume_notick", a_tick[0], 1'b0);
      step();
      chk("resume_tick", a_tick[0], 1'b1);
      step();
      chk("resume_cnt",  a_cnt[0],  8'h11);

      // High score across a clear
      run_until(0, 8'h25, "to25");
      chk("pre_clear_cnt", a_cnt[0], 8'h25);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_cnt",  a_cnt[0],  8'h00);
      chk("clr_high", a_high[0], 8'h25);
      chk("clr_new",  a_new[0],  1'b0);
      run_until(0, 8'h07, "to07");
      chk("at07_high", a_high[0], 8'h25);
      chk("at07_new",  a_new[0],  1'b0);
      run_until(0, 8'h26, "to26");
      chk("at26_high", a_high[0], 8'h25);
      chk("at26_new",  a_new[0],  1'b0);
      step();
      chk("at26_high_next", a_high[0], 8'h26);
      chk("at26_new_next",  a_new[0],  1'b1);

      // Tick plus bonus past 99
      run_until(0, 8'h98, "to98");
      wait_tick(0, "tick98");
      chk("pre_ovf_bw", a_cnt[0], 8'h98);
      chk("pre_ovf_bs", a_cnt[1], 8'h98);
      add_pulse = 1'b1;
      add_val   = 4'd5;
      step();
      chk("wrap_cnt", a_cnt[0], 8'h04);
      chk("wrap_ovf", a_ovf[0], 1'b1);
      chk("sat_cnt",  a_cnt[1], 8'h99);
      chk("sat_ovf",  a_ovf[1], 1'b1);
      add_val = 4'd15;
      step();
      add_pulse = 1'b0;
      chk("clamp_cnt", a_cnt[0], 8'h13);
      chk("clamp_sat", a_cnt[1], 8'h99);

      // Asynchronous reset between clock edges
      run_until(0, 8'h33, "to33");
      resetn = 1'b0;
      model_reset();
      #1;
      chk("arst_cnt",  a_cnt[0],  8'h00);
      chk("arst_high", a_high[0], 8'h00);
      chk("arst_tick", a_tick[0], 1'b0);
      chk("arst_ovf",  a_ovf[1],  1'b0);
      chk("arst_new",  a_new[0],  1'b0);
      chk("arst_hex",  a_hex[0],  14'b1000000_1000000);
      #1 resetn = 1'b1;

      // Hex flavour: carry from 0x0F and saturation at 0xFF
      add_pulse = 1'b1;
      add_val   = 4'd15;
      step();
      add_pulse = 1'b0;
      chk("hex_0f",   a_cnt[2], 8'h0F);
      chk("bcd_clmp", a_cnt[0], 8'h09);
      wait_tick(2, "tick0f");
      step();
      chk("hex_10", a_cnt[2], 8'h10);
      n = 0;
      while (m_cnt[2] != 255 && n < 200) begin
         a = 255 - m_cnt[2] - int'(m_tick[2]);
         if (a > 15) a = 15;
         add_pulse = (a > 0);
         add_val   = 4'(a);
         step();
         n++;
      end
      add_pulse = 1'b0;
      chk("hex_ff_pre", a_cnt[2], 8'hFF);
      wait_tick(2, "tickff");
      step();
      chk("hex_ff_cnt", a_cnt[2], 8'hFF);
      chk("hex_ff_ovf", a_ovf[2], 1'b1);
      chk("hex_ff_seg", a_hex[2], 14'b0001110_0001110);

      repeat (2) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/bcd_score_counter.md
BCD_SCORE_COUNTER -- requirements
Module: bcd_score_counter

Interface
REQ-001 Parameter DIGITS, default 6, sets the number of 4-bit display digits (1..8).
REQ-002 Parameter TICK_DIV, default 50_000_000, sets the clk cycles per score tick (>=2).
REQ-003 Parameter BCD, default 1: 1 gives decimal digits 0-9, 0 gives hex digits 0-F.
REQ-004 Parameter SATURATE, default 1: 1 holds at max value, 0 wraps to zero.
REQ-005 clk  in  1  system clock; one clock domain only.
REQ-006 resetn  in  1  asynchronous active-low reset.
REQ-007 enable  in  1  run control; tick divider and score advance only while high.
REQ-008 clear  in  1  synchronous restart of the current score.
REQ-009 add_pulse  in  1  one-cycle bonus request.
REQ-010 add_val  in  4  bonus amount, 0-9, applied to digit 0.
REQ-011 count  out  4*DIGITS  current score, digit 0 in bits [3:0].
REQ-012 high_score  out  4*DIGITS  best score since reset.
REQ-013 tick  out  1  one-cycle pulse on each divider expiry.
REQ-014 overflow  out  1  sticky flag; an increment exceeded max value.
REQ-015 new_high  out  1  high while high_score tracks the current run.
REQ-016 hex  out  7*DIGITS  active-low 7-segment codes; digit n in bits [7n+6:7n], bit 0 = segment a, bit 6 = segment g.

Function
REQ-017 Divider: down-counter loads TICK_DIV-1, decrements while enable, reloads on reaching 0, holds while enable is low.
REQ-018 tick is registered and asserted for exactly one cycle when the divider is 0 and enable is high.
REQ-019 Per-cycle increment inc = (tick ? 1 : 0) + (add_pulse & enable ? add_val : 0), range 0..10, applied to count on the next clk edge.
REQ-020 BCD=1: digit-wise add with carry; a digit reaching >=10 subtracts 10 and carries 1 to the next digit.
REQ-021 BCD=0: plain binary add across 4*DIGITS bits.
REQ-022 Max value: all digits 9 (BCD=1) or all digits F (BCD=0).
REQ-023 If count+inc exceeds max: SATURATE=1 gives count = max; SATURATE=0 keeps the low 4*DIGITS result (BCD modulo 10^DIGITS); in both cases overflow sets.
REQ-024 add_val > 9 with BCD=1 is treated as 9.
REQ-025 clear has priority over tick and add: count = 0, divider reloads TICK_DIV-1, overflow = 0, new_high = 0, high_score unchanged.
REQ-026 high_score <= count one cycle after count > high_score (digit-wise magnitude compare); new_high sets on that update and stays set until clear or reset.
REQ-027 hex is combinational from count: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110 (bits g..a).

Reset
REQ-028 resetn low, at any time and immediately: count=0, high_score=0, tick=0, overflow=0, new_high=0, divider=TICK_DIV-1.
REQ-029 On the first clk edge after resetn deasserts, the block resumes counting from these values.

Structure
REQ-030 A shared package holds SEG_* 7-segment constants, the digit width (4) and the max-digit constants for BCD and hex.
REQ-031 One sub-module, tick_divider (parameter TICK_DIV; ports clk, resetn, enable, reload, tick), implements REQ-017/018.
REQ-032 The segment decode is a function in the package, replicated via generate per digit.

Verification (TICK_DIV=4, DIGITS=2 unless stated)
REQ-033 enable=1 for 40 cycles after reset -> tick every 4th cycle; count=0x10 (BCD) after 10 ticks; hex[6:0]=1000000, hex[13:7]=1111001.
REQ-034 count=0x98, tick and add_pulse with add_val=5 in the same cycle -> count=0x04 with SATURATE=0 and overflow=1; count=0x99 with SATURATE=1.
REQ-035 Run to 0x25, clear, run to 0x07 -> high_score=0x25, new_high=0; continue to 0x26 -> high_score=0x26 one cycle later, new_high=1.
REQ-036 BCD=0, count=0x0F, tick -> count=0x10; count=0xFF, tick, SATURATE=1 -> count=0xFF, overflow=1.
REQ-037 enable dropped mid-divide for 10 cycles -> no tick and count held; divider resumes from the held value.
REQ-038 resetn pulsed low between clk edges at count=0x33 -> all outputs zero before the next edge; high_score=0.
